// File: rtl/reorder_buffer_pkg.sv
// Shared definitions for the reorder buffer.
// - ROB_SIZE / ROB_TAG_W: default entry count and tag width.
// - rob_type_e: how an entry behaves when it retires.
// - commit_state_e: states of the commit sequencer.
// - OP_*: 7-bit opcodes found in name[16:10] on the issue interface.
// - op_to_type(): maps an opcode to its retirement behaviour.
package reorder_buffer_pkg;

  localparam int ROB_SIZE  = 16;
  localparam int ROB_TAG_W = 4;

  typedef enum logic [1:0] {
    ROB_REG   = 2'd0,
    ROB_STORE = 2'd1,
    ROB_BR    = 2'd2,
    ROB_JALR  = 2'd3
  } rob_type_e;

  typedef enum logic {
    COMMIT_IDLE = 1'b0,
    COMMIT_GAP  = 1'b1
  } commit_state_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_BINARY = 7'b0010011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_SB_ALL = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // Unknown opcodes fall back to a register-writing entry so the ROB never stalls on them.
  function automatic rob_type_e op_to_type(input logic [6:0] op);
    rob_type_e t;
    case (op)
      OP_STORE:  t = ROB_STORE;
      OP_SB_ALL: t = ROB_BR;
      OP_JALR:   t = ROB_JALR;
      default:   t = ROB_REG;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/reorder_buffer_entry_file.sv
// Entry storage for the reorder buffer.
// Ports:
//   clk, rst             clock, asynchronous active-high reset (clears busy/done)
//   flush                clears every busy/done bit; beats alloc, writeback and retire
//   alloc_*              allocate port: marks alloc_idx busy, not done, stores type/dest/pred
//   wb_*                 CDB port: completes a busy entry and captures value/taken/target
//   retire_en/idx        clears busy on the retiring entry
//   head_idx, head_*     combinational read of the entry at head_idx
module reorder_buffer_entry_file
  import reorder_buffer_pkg::*;
#(
  parameter int DEPTH = ROB_SIZE,
  parameter int TAG_W = ROB_TAG_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             alloc_en,
  input  logic [TAG_W-1:0] alloc_idx,
  input  rob_type_e        alloc_type,
  input  logic [4:0]       alloc_dest,
  input  logic             alloc_pred,
  input  logic             wb_en,
  input  logic [TAG_W-1:0] wb_idx,
  input  logic [31:0]      wb_value,
  input  logic             wb_taken,
  input  logic [31:0]      wb_target,
  input  logic             retire_en,
  input  logic [TAG_W-1:0] retire_idx,
  input  logic [TAG_W-1:0] head_idx,
  output logic             head_busy,
  output logic             head_done,
  output rob_type_e        head_type,
  output logic [4:0]       head_dest,
  output logic             head_pred,
  output logic [31:0]      head_value,
  output logic             head_taken,
  output logic [31:0]      head_target
);

  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] done;

  rob_type_e   type_mem   [DEPTH];
  logic [4:0]  dest_mem   [DEPTH];
  logic        pred_mem   [DEPTH];
  logic [31:0] value_mem  [DEPTH];
  logic        taken_mem  [DEPTH];
  logic [31:0] target_mem [DEPTH];

  // Writebacks only count for entries that are live before this edge.
  logic wb_accept;
  assign wb_accept = wb_en & busy[wb_idx] & ~flush;

  // Control bits. Later statements win, so a fresh allocation overrides a stale
  // done bit left on a slot that was retired in the same cycle it was written back.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= '0;
      done <= '0;
    end else if (flush) begin
      busy <= '0;
      done <= '0;
    end else begin
      if (retire_en) busy[retire_idx] <= 1'b0;
      if (wb_accept) done[wb_idx] <= 1'b1;
      if (alloc_en) begin
        busy[alloc_idx] <= 1'b1;
        done[alloc_idx] <= 1'b0;
      end
    end
  end

  // Payload needs no reset: it is only read once busy&done is set.
  always_ff @(posedge clk) begin
    if (alloc_en) begin
      type_mem[alloc_idx] <= alloc_type;
      dest_mem[alloc_idx] <= alloc_dest;
      pred_mem[alloc_idx] <= alloc_pred;
    end
    if (wb_accept) begin
      value_mem[wb_idx]  <= wb_value;
      taken_mem[wb_idx]  <= wb_taken;
      target_mem[wb_idx] <= wb_target;
    end
  end

  assign head_busy   = busy[head_idx];
  assign head_done   = done[head_idx];
  assign head_type   = type_mem[head_idx];
  assign head_dest   = dest_mem[head_idx];
  assign head_pred   = pred_mem[head_idx];
  assign head_value  = value_mem[head_idx];
  assign head_taken  = taken_mem[head_idx];
  assign head_target = target_mem[head_idx];

endmodule

// File: rtl/reorder_buffer.sv
// Reorder buffer: allocates entries in program order from the decoder, collects CDB
// results, and retires one entry every other cycle at most.
// Ports:
//   clk, rst, rdy                       clock, async active-high reset, global enable
//   ready, rd, name, pred_taken         issue request; success/ROB_Tail answer it
//   cdb_valid/tag/value/taken/target    result broadcast
//   ROB_Ready/Value/Addr/Tag            register-file commit pulse and data
//   store_commit, store_tag             store release pulse
//   clr, redirect_pc                    flush pulse and fetch restart address
module reorder_buffer
  import reorder_buffer_pkg::*;
#(
  parameter int DEPTH = ROB_SIZE,
  parameter int TAG_W = ROB_TAG_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             ready,
  input  logic [31:0]      rd,
  input  logic [16:0]      name,
  input  logic             pred_taken,
  output logic             success,
  output logic [TAG_W-1:0] ROB_Tail,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic [31:0]      cdb_value,
  input  logic             cdb_taken,
  input  logic [31:0]      cdb_target,
  output logic             ROB_Ready,
  output logic [31:0]      ROB_Value,
  output logic [4:0]       ROB_Addr,
  output logic [TAG_W-1:0] ROB_Tag,
  output logic             store_commit,
  output logic [TAG_W-1:0] store_tag,
  output logic             clr,
  output logic [31:0]      redirect_pc
);

  localparam logic [TAG_W:0] FULL_COUNT = (TAG_W+1)'(DEPTH);

  logic [TAG_W-1:0] head;
  logic [TAG_W-1:0] tail;
  logic [TAG_W:0]   count;
  commit_state_e    state;

  rob_type_e   head_type;
  logic        head_busy, head_done, head_pred, head_taken;
  logic [4:0]  head_dest;
  logic [31:0] head_value, head_target;

  logic unused_bits;
  assign unused_bits = ^{rd[31:5], name[9:0]};

  // No allocation during the flush pulse: the decoder is being redirected.
  assign success  = rdy & ~rst & (count < FULL_COUNT) & ~clr;
  assign ROB_Tail = tail;

  logic alloc, commit_go, flush_now;
  assign alloc     = ready & success;
  assign commit_go = rdy & (state == COMMIT_IDLE) & head_busy & head_done;
  assign flush_now = commit_go &
                     (((head_type == ROB_BR) & (head_taken != head_pred)) |
                      (head_type == ROB_JALR));

  reorder_buffer_entry_file #(
    .DEPTH (DEPTH),
    .TAG_W (TAG_W)
  ) u_entries (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush_now),
    .alloc_en    (alloc),
    .alloc_idx   (tail),
    .alloc_type  (op_to_type(name[16:10])),
    .alloc_dest  (rd[4:0]),
    .alloc_pred  (pred_taken),
    .wb_en       (rdy & cdb_valid),
    .wb_idx      (cdb_tag),
    .wb_value    (cdb_value),
    .wb_taken    (cdb_taken),
    .wb_target   (cdb_target),
    .retire_en   (commit_go),
    .retire_idx  (head),
    .head_idx    (head),
    .head_busy   (head_busy),
    .head_done   (head_done),
    .head_type   (head_type),
    .head_dest   (head_dest),
    .head_pred   (head_pred),
    .head_value  (head_value),
    .head_taken  (head_taken),
    .head_target (head_target)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      state        <= COMMIT_IDLE;
      ROB_Ready    <= 1'b0;
      ROB_Value    <= '0;
      ROB_Addr     <= '0;
      ROB_Tag      <= '0;
      store_commit <= 1'b0;
      store_tag    <= '0;
      clr          <= 1'b0;
      redirect_pc  <= '0;
    end else begin
      // Pulses last one cycle even when rdy is low.
      ROB_Ready    <= 1'b0;
      store_commit <= 1'b0;
      clr          <= 1'b0;
      if (rdy) begin
        if (flush_now) begin
          head  <= '0;
          tail  <= '0;
          count <= '0;
        end else begin
          if (alloc)     tail <= tail + TAG_W'(1);
          if (commit_go) head <= head + TAG_W'(1);
          case ({alloc, commit_go})
            2'b10:   count <= count + (TAG_W+1)'(1);
            2'b01:   count <= count - (TAG_W+1)'(1);
            default: count <= count;
          endcase
        end

        case (state)
          COMMIT_IDLE: begin
            if (commit_go) begin
              state <= COMMIT_GAP;
              case (head_type)
                ROB_REG: begin
                  ROB_Ready <= 1'b1;
                  ROB_Value <= head_value;
                  ROB_Addr  <= head_dest;
                  ROB_Tag   <= head;
                end
                ROB_STORE: begin
                  store_commit <= 1'b1;
                  store_tag    <= head;
                end
                ROB_BR: begin
                  if (head_taken != head_pred) begin
                    clr         <= 1'b1;
                    redirect_pc <= head_target;
                  end
                end
                default: begin
                  ROB_Ready   <= 1'b1;
                  ROB_Value   <= head_value;
                  ROB_Addr    <= head_dest;
                  ROB_Tag     <= head;
                  clr         <= 1'b1;
                  redirect_pc <= head_target;
                end
              endcase
            end
          end
          default: state <= COMMIT_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
module tb_reorder_buffer;
  import reorder_buffer_pkg::*;

  localparam int K_REG = 0, K_STORE = 1, K_BR = 2, K_JALR = 3;

  typedef struct {
    int          kind;
    logic [4:0]  addr;
    logic [31:0] value;
    logic [3:0]  tag;
    logic [31:0] pc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, rdy, ready, pred_taken, success;
  logic [31:0] rd;
  logic [16:0] name;
  logic [3:0]  ROB_Tail;
  logic        cdb_valid, cdb_taken;
  logic [3:0]  cdb_tag;
  logic [31:0] cdb_value, cdb_target;
  logic        ROB_Ready, store_commit, clr;
  logic [31:0] ROB_Value, redirect_pc;
  logic [4:0]  ROB_Addr;
  logic [3:0]  ROB_Tag, store_tag;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  bit   prev_any = 1'b0;

  always #5 clk = ~clk;

  reorder_buffer dut (
    .clk(clk), .rst(rst), .rdy(rdy), .ready(ready), .rd(rd), .name(name),
    .pred_taken(pred_taken), .success(success), .ROB_Tail(ROB_Tail),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .cdb_taken(cdb_taken), .cdb_target(cdb_target),
    .ROB_Ready(ROB_Ready), .ROB_Value(ROB_Value), .ROB_Addr(ROB_Addr), .ROB_Tag(ROB_Tag),
    .store_commit(store_commit), .store_tag(store_tag), .clr(clr), .redirect_pc(redirect_pc)
  );

  // Scoreboard: compares every retirement pulse against the oldest expectation.
  always @(negedge clk) begin
    bit   any;
    int   obs;
    exp_t e;
    if (rst) begin
      prev_any = 1'b0;
    end else begin
      any = ROB_Ready | store_commit | clr;
      if (any) begin
        checks++;
        if (prev_any) begin
          errors++;
          $display("FAIL pulse_gap: pulse in consecutive cycles, required a low cycle between");
        end
        obs = (ROB_Ready && clr) ? K_JALR : ROB_Ready ? K_REG : store_commit ? K_STORE : K_BR;
        if (ROB_Ready && store_commit) begin
          errors++;
          $display("FAIL pulse_mix: ROB_Ready and store_commit both high");
        end
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pulse: kind=%0d tag=%0d addr=%0d, required none", obs, ROB_Tag, ROB_Addr);
        end else begin
          e = exp_q.pop_front();
          if (obs != e.kind) begin
            errors++;
            $display("FAIL commit_kind: got %0d required %0d (tag %0d)", obs, e.kind, e.tag);
          end else begin
            if (obs == K_REG || obs == K_JALR) begin
              checks++;
              if (ROB_Addr !== e.addr || ROB_Value !== e.value || ROB_Tag !== e.tag) begin
                errors++;
                $display("FAIL commit_data: addr=%0d value=%h tag=%0d required addr=%0d value=%h tag=%0d",
                         ROB_Addr, ROB_Value, ROB_Tag, e.addr, e.value, e.tag);
              end
            end
            if (obs == K_STORE) begin
              checks++;
              if (store_tag !== e.tag) begin
                errors++;
                $display("FAIL store_tag: got %0d required %0d", store_tag, e.tag);
              end
            end
            if (obs == K_BR || obs == K_JALR) begin
              checks++;
              if (redirect_pc !== e.pc) begin
                errors++;
                $display("FAIL redirect_pc: got %h required %h", redirect_pc, e.pc);
              end
            end
          end
          $display("commit kind=%0d tag=%0d addr=%0d value=%h pc=%h", obs, ROB_Tag, ROB_Addr, ROB_Value, redirect_pc);
        end
      end
      prev_any = any;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; rdy = 1'b1; ready = 1'b0; cdb_valid = 1'b0;
    rd = '0; name = '0; pred_taken = 1'b0;
    cdb_tag = '0; cdb_value = '0; cdb_taken = 1'b0; cdb_target = '0;
    exp_q.delete();
    tick(); tick();
    rst = 1'b0;
    #1;
  endtask

  // Drives one issue cycle; when expect_commit is set, queues what its retirement must look like.
  task automatic issue_op(input logic [6:0] op, input logic [4:0] rdi, input logic pred,
                          input bit expect_commit, input logic [31:0] val, input logic [31:0] pc);
    exp_t e;
    if (expect_commit) begin
      e.kind  = (op == OP_STORE) ? K_STORE : (op == OP_SB_ALL) ? K_BR : (op == OP_JALR) ? K_JALR : K_REG;
      e.addr  = rdi;
      e.value = val;
      e.tag   = ROB_Tail;
      e.pc    = pc;
      exp_q.push_back(e);
    end
    ready = 1'b1; rd = {27'd0, rdi}; name = {op, 10'd0}; pred_taken = pred;
    tick();
    ready = 1'b0;
    $display("issue op=%b rd=%0d tag=%0d", op, rdi, e.tag);
  endtask

  task automatic cdb_write(input logic [3:0] tag, input logic [31:0] val,
                           input logic taken, input logic [31:0] target);
    cdb_valid = 1'b1; cdb_tag = tag; cdb_value = val; cdb_taken = taken; cdb_target = target;
    tick();
    cdb_valid = 1'b0;
  endtask

  task automatic wait_drain(input string label);
    int n = 0;
    while (exp_q.size() != 0 && n < 80) begin
      tick();
      n++;
    end
    repeat (4) tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d commits outstanding, required 0", label, exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; rdy = 1'b1; ready = 1'b0; cdb_valid = 1'b0;
    rd = '0; name = '0; pred_taken = 1'b0;
    cdb_tag = '0; cdb_value = '0; cdb_taken = 1'b0; cdb_target = '0;
    tick();
    checks++;
    if (success !== 1'b0) begin errors++; $display("FAIL reset_success: got %b required 0", success); end
    rst = 1'b0;
    #1;
    checks++;
    if (ROB_Tail !== 4'd0 || ROB_Ready !== 1'b0 || store_commit !== 1'b0 || clr !== 1'b0 ||
        ROB_Value !== 32'd0 || redirect_pc !== 32'd0) begin
      errors++;
      $display("FAIL reset_outputs: tail=%0d rdy=%b st=%b clr=%b val=%h pc=%h required all 0",
               ROB_Tail, ROB_Ready, store_commit, clr, ROB_Value, redirect_pc);
    end
    checks++;
    if (success !== 1'b1) begin errors++; $display("FAIL post_reset_success: got %b required 1", success); end
  endtask

  task automatic test_single();
    do_reset();
    issue_op(OP_BINARY, 5'd5, 1'b0, 1'b1, 32'd42, 32'd0);
    checks++;
    if (ROB_Tail !== 4'd1) begin errors++; $display("FAIL single_tail: got %0d required 1", ROB_Tail); end
    cdb_write(4'd0, 32'd42, 1'b0, 32'd0);
    wait_drain("single");
  endtask

  task automatic test_full();
    int waited = 0;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (success !== 1'b1) begin errors++; $display("FAIL full_alloc%0d: success=%b required 1", i, success); end
      issue_op(OP_BINARY, 5'(i + 1), 1'b0, 1'b1, 32'(100 + i), 32'd0);
    end
    checks++;
    if (success !== 1'b0) begin errors++; $display("FAIL full_17th: success=%b required 0", success); end
    checks++;
    if (ROB_Tail !== 4'd0) begin errors++; $display("FAIL full_tail_wrap: got %0d required 0", ROB_Tail); end
    cdb_write(4'd0, 32'd100, 1'b0, 32'd0);
    while (success !== 1'b1 && waited < 10) begin tick(); waited++; end
    checks++;
    if (success !== 1'b1) begin errors++; $display("FAIL full_reopen: success=%b required 1", success); end
    issue_op(OP_LOAD, 5'd9, 1'b0, 1'b1, 32'd200, 32'd0);
    checks++;
    if (ROB_Tail !== 4'd1) begin errors++; $display("FAIL full_tail_after: got %0d required 1", ROB_Tail); end
    for (int i = 1; i < 16; i++) cdb_write(4'(i), 32'(100 + i), 1'b0, 32'd0);
    cdb_write(4'd0, 32'd200, 1'b0, 32'd0);
    wait_drain("full");
  endtask

  task automatic test_out_of_order();
    do_reset();
    for (int i = 0; i < 3; i++) issue_op(OP_R, 5'(10 + i), 1'b0, 1'b1, 32'(32'hA0 + i), 32'd0);
    cdb_write(4'd2, 32'hA2, 1'b0, 32'd0);
    cdb_write(4'd1, 32'hA1, 1'b0, 32'd0);
    checks++;
    if (ROB_Ready !== 1'b0) begin errors++; $display("FAIL ooo_early: ROB_Ready=%b required 0", ROB_Ready); end
    cdb_write(4'd0, 32'hA0, 1'b0, 32'd0);
    wait_drain("ooo");
  endtask

  task automatic test_mispredict();
    do_reset();
    issue_op(OP_SB_ALL, 5'd0, 1'b0, 1'b1, 32'd0, 32'h100);
    for (int i = 0; i < 3; i++) issue_op(OP_BINARY, 5'(20 + i), 1'b0, 1'b0, 32'd0, 32'd0);
    cdb_write(4'd1, 32'h11, 1'b0, 32'd0);
    cdb_write(4'd2, 32'h22, 1'b0, 32'd0);
    cdb_write(4'd0, 32'd0, 1'b1, 32'h100);
    wait_drain("mispredict");
    checks++;
    if (ROB_Tail !== 4'd0 || success !== 1'b1) begin
      errors++;
      $display("FAIL mispredict_empty: tail=%0d success=%b required 0/1", ROB_Tail, success);
    end
  endtask

  task automatic test_store_branch();
    do_reset();
    issue_op(OP_STORE, 5'd0, 1'b0, 1'b1, 32'd0, 32'd0);
    issue_op(OP_SB_ALL, 5'd0, 1'b1, 1'b0, 32'd0, 32'd0);
    issue_op(OP_LUI, 5'd7, 1'b0, 1'b1, 32'd77, 32'd0);
    cdb_write(4'd0, 32'd0, 1'b0, 32'd0);
    cdb_write(4'd1, 32'd0, 1'b1, 32'h300);
    cdb_write(4'd2, 32'd77, 1'b0, 32'd0);
    wait_drain("store_branch");
  endtask

  task automatic test_jalr();
    do_reset();
    issue_op(OP_JALR, 5'd1, 1'b0, 1'b1, 32'h44, 32'h200);
    issue_op(OP_BINARY, 5'd2, 1'b0, 1'b0, 32'd0, 32'd0);
    cdb_write(4'd1, 32'h99, 1'b0, 32'd0);
    cdb_write(4'd0, 32'h44, 1'b0, 32'h200);
    wait_drain("jalr");
  endtask

  task automatic test_stall();
    do_reset();
    issue_op(OP_AUIPC, 5'd3, 1'b0, 1'b1, 32'h33, 32'd0);
    cdb_write(4'd0, 32'h33, 1'b0, 32'd0);
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (ROB_Ready !== 1'b0 || success !== 1'b0) begin
        errors++;
        $display("FAIL stall_frozen%0d: ROB_Ready=%b success=%b required 0/0", i, ROB_Ready, success);
      end
    end
    rdy = 1'b1;
    wait_drain("stall");
  endtask

  task automatic test_reset_mid();
    do_reset();
    issue_op(OP_BINARY, 5'd3, 1'b0, 1'b1, 32'h55, 32'd0);
    for (int i = 0; i < 4; i++) issue_op(OP_BINARY, 5'(4 + i), 1'b0, 1'b0, 32'd0, 32'd0);
    cdb_write(4'd0, 32'h55, 1'b0, 32'd0);
    wait_drain("reset_mid_pre");
    checks++;
    if (ROB_Value !== 32'h55 || ROB_Tail !== 4'd5) begin
      errors++;
      $display("FAIL reset_mid_before: value=%h tail=%0d required 55/5", ROB_Value, ROB_Tail);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (success !== 1'b0 || ROB_Value !== 32'd0 || ROB_Addr !== 5'd0 || ROB_Tail !== 4'd0 ||
        ROB_Ready !== 1'b0 || redirect_pc !== 32'd0) begin
      errors++;
      $display("FAIL reset_mid_outputs: success=%b value=%h addr=%0d tail=%0d required all 0",
               success, ROB_Value, ROB_Addr, ROB_Tail);
    end
    exp_q.delete();
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (ROB_Tail !== 4'd0) begin errors++; $display("FAIL reset_mid_tag: got %0d required 0", ROB_Tail); end
    issue_op(OP_JAL, 5'd8, 1'b0, 1'b1, 32'h88, 32'd0);
    cdb_write(4'd0, 32'h88, 1'b0, 32'd0);
    wait_drain("reset_mid_post");
  endtask

  initial begin
    test_reset();
    test_single();
    test_full();
    test_out_of_order();
    test_mispredict();
    test_store_branch();
    test_jalr();
    test_stall();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
